// File: rtl/pipo_load_arbiter_if.sv
// Load-port bundle between requesting blocks and the shared-PIPO load arbiter.
// master = requester side, slave = arbiter side.
interface pipo_load_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              reg_load;
  logic [N-1:0]      reg_data;
  logic              busy;

  modport master (
    output req, req_data,
    input  gnt, ack, reg_load, reg_data, busy
  );

  modport slave (
    input  req, req_data,
    output gnt, ack, reg_load, reg_data, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter for the load port of a shared PIPO register: grant, one-cycle load/ack, then hold-off.
// Optional PIPO_ARB_LOAD_CNT_EN adds load_cnt and last_gnt_id outputs.
module pipo_load_arbiter #(
  parameter int N        = 8,
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  pipo_load_arbiter_if.slave bus
`ifdef PIPO_ARB_LOAD_CNT_EN
  ,
  output logic [15:0]       load_cnt,
  output logic [2:0]        last_gnt_id
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam logic [3:0] HOLD_INIT = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_q;
  logic [3:0]      cnt;

  logic            found;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic [N-1:0]    win_data;

  // Search ptr+1, ptr+2, ... modulo NREQ; the first pending request wins.
  always_comb begin
    found    = 1'b0;
    win      = ptr;
    win_oh   = '0;
    win_data = '0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && bus.req[k] && (k == ((int'(ptr) + i) % NREQ))) begin
          found = 1'b1;
          win   = PW'(k);
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (found && (win == PW'(k))) begin
        win_oh[k] = 1'b1;
        win_data  = bus.req_data[k*N +: N];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = LOAD;
      LOAD:    state_next = (HOLD_CYC > 0) ? HOLD : IDLE;
      HOLD:    if (cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Load/ack are registered at the grant edge so they coincide with the LOAD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.gnt      <= '0;
      bus.ack      <= '0;
      bus.reg_load <= 1'b0;
      bus.reg_data <= '0;
      ptr          <= PW'(NREQ - 1);
      win_q        <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.gnt      <= win_oh;
            bus.ack      <= win_oh;
            bus.reg_load <= 1'b1;
            bus.reg_data <= win_data;
            win_q        <= win;
          end
        end
        LOAD: begin
          bus.gnt      <= '0;
          bus.ack      <= '0;
          bus.reg_load <= 1'b0;
          ptr          <= win_q;
          cnt          <= HOLD_INIT;
        end
        HOLD: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

`ifdef PIPO_ARB_LOAD_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt    <= '0;
      last_gnt_id <= '0;
    end else begin
      if (state == IDLE && found) last_gnt_id <= 3'(win);
      if (state == LOAD)          load_cnt    <= load_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed, table-driven bench for pipo_load_arbiter (N=8, NREQ=4, HOLD_CYC=2).
// Counter checks are compiled only when PIPO_ARB_LOAD_CNT_EN is defined.
module tb_pipo_load_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipo_load_arbiter_if #(.N(8), .NREQ(4)) bus ();

`ifdef PIPO_ARB_LOAD_CNT_EN
  logic [15:0] load_cnt;
  logic [2:0]  last_gnt_id;
`endif

  pipo_load_arbiter #(.N(8), .NREQ(4), .HOLD_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef PIPO_ARB_LOAD_CNT_EN
    ,
    .load_cnt    (load_cnt),
    .last_gnt_id (last_gnt_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_v;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        load;
    logic [7:0]  rdata;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                              input logic [3:0] g, input logic ld, input logic [7:0] rd,
                              input logic b);
    vec_t v;
    v.rst_v = r; v.req = rq; v.data = d; v.gnt = g; v.load = ld; v.rdata = rd; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic ld,
                           input logic [7:0] rd, input logic b);
    check({tag, "_gnt"},  32'(bus.gnt),      32'(g));
    check({tag, "_ack"},  32'(bus.ack),      32'(g));
    check({tag, "_load"}, 32'(bus.reg_load), 32'(ld));
    check({tag, "_data"}, 32'(bus.reg_data), 32'(rd));
    check({tag, "_busy"}, 32'(bus.busy),     32'(b));
  endtask

  task automatic step(input logic [3:0] rq, input logic [31:0] d);
    bus.req      = rq;
    bus.req_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d2, d3, d4;
    logic [3:0]  g;
    logic [7:0]  rd;
    int          w;

    n_checks = 0;
    n_fail   = 0;
    d2 = 32'h00A5_0000;
    d3 = 32'h4433_2211;
    d4 = 32'h0000_BBAA;

    // Single requester 2: load, two hold cycles, back to idle with data retained.
    add(1, 4'b0100, d2, 4'b0100, 1, 8'hA5, 1);
    add(1, 4'b0000, d2, 4'b0000, 0, 8'hA5, 1);
    add(1, 4'b0000, d2, 4'b0000, 0, 8'hA5, 1);
    add(1, 4'b0000, d2, 4'b0000, 0, 8'hA5, 0);
    add(1, 4'b0000, d2, 4'b0000, 0, 8'hA5, 0);
    // Reset, then all four requesting: one load every 4 cycles, 0 -> 1 -> 2 -> 3 -> 0.
    add(0, 4'b0000, d3, 4'b0000, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      w  = k % 4;
      g  = 4'(1 << w);
      rd = d3[w*8 +: 8];
      add(1, 4'b1111, d3, g,       1, rd, 1);
      add(1, 4'b1111, d3, 4'b0000, 0, rd, 1);
      add(1, 4'b1111, d3, 4'b0000, 0, rd, 1);
      add(1, 4'b1111, d3, 4'b0000, 0, rd, 0);
    end
    // Rotation: grant 1, then with 0 and 1 pending, 0 wins before 1 again.
    add(1, 4'b0010, d4, 4'b0010, 1, 8'hBB, 1);
    add(1, 4'b0011, d4, 4'b0000, 0, 8'hBB, 1);
    add(1, 4'b0011, d4, 4'b0000, 0, 8'hBB, 1);
    add(1, 4'b0011, d4, 4'b0000, 0, 8'hBB, 0);
    add(1, 4'b0011, d4, 4'b0001, 1, 8'hAA, 1);
    add(1, 4'b0010, d4, 4'b0000, 0, 8'hAA, 1);
    add(1, 4'b0010, d4, 4'b0000, 0, 8'hAA, 1);
    add(1, 4'b0010, d4, 4'b0000, 0, 8'hAA, 0);
    add(1, 4'b0010, d4, 4'b0010, 1, 8'hBB, 1);
    add(1, 4'b0000, d4, 4'b0000, 0, 8'hBB, 1);
    add(1, 4'b0000, d4, 4'b0000, 0, 8'hBB, 1);
    add(1, 4'b0000, d4, 4'b0000, 0, 8'hBB, 0);

    // Reset held for three cycles, then ten idle cycles.
    rst          = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 4'b0000, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(4'b0000, 32'h0);
      check_all($sformatf("idle%0d", c), 4'b0000, 1'b0, 8'h00, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_v;
      step(vecs[i].req, vecs[i].data);
      check_all($sformatf("v%0d", i), vecs[i].gnt, vecs[i].load, vecs[i].rdata, vecs[i].busy);
    end
    rst = 1'b1;

    // Reset asserted during LOAD clears outputs without waiting for a clock edge.
    step(4'b0001, 32'h0000_00E7);
    check_all("preload", 4'b0001, 1'b1, 8'hE7, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 1'b0, 8'h00, 1'b0);
    bus.req = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(4'b0000, 32'h0);
    check_all("no_reissue", 4'b0000, 1'b0, 8'h00, 1'b0);
    // Pointer restarted at NREQ-1, so requester 0 beats requester 3.
    step(4'b1001, 32'hC300_005A);
    check_all("ptr_rst", 4'b0001, 1'b1, 8'h5A, 1'b1);
    step(4'b1000, 32'hC300_005A);
    step(4'b1000, 32'hC300_005A);
    step(4'b1000, 32'hC300_005A);
    check_all("pre_r3", 4'b0000, 1'b0, 8'h5A, 1'b0);
    step(4'b1000, 32'hC300_005A);
    check_all("r3_gnt", 4'b1000, 1'b1, 8'hC3, 1'b1);
    step(4'b0000, 32'h0);
    check_all("r3_hold", 4'b0000, 1'b0, 8'hC3, 1'b1);

`ifdef PIPO_ARB_LOAD_CNT_EN
    rst = 1'b0;
    #1;
    check("cnt_rst", 32'(load_cnt), 32'h0);
    check("id_rst",  32'(last_gnt_id), 32'h0);
    rst = 1'b1;
    step(4'b0000, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 32'h0000_0011);
      repeat (3) step(4'b0000, 32'h0);
    end
    check("cnt_5", 32'(load_cnt), 32'd5);
    force dut.load_cnt = 16'hFFFF;
    #1;
    release dut.load_cnt;
    step(4'b0100, 32'h0033_0000);
    repeat (3) step(4'b0000, 32'h0);
    check("cnt_wrap", 32'(load_cnt), 32'h0);
    check("last_id",  32'(last_gnt_id), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
